// File: rtl/imem_if.sv
// imem_if: word-fetch handshake between the fetch stage and instruction memory.
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, single-outstanding imem fetch, one-entry skid buffer and IF/ID register.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    imem_if.master      imem,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t state, state_nxt;
    logic [31:0] req_addr, resp_pc, skid_instr, skid_pc4, pcf_nxt;
    logic drop, redir, deliver_mem, deliver_skid;

    assign imem.req  = state == REQ;
    assign imem.addr = req_addr;

    always_comb begin
        redir = PCSrcD && ValidD && !StallF;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = imem.gnt ? WAIT : REQ;
            WAIT:    state_nxt = !imem.rvalid ? WAIT : (drop || redir || !StallF) ? REQ : HOLD;
            HOLD:    state_nxt = StallF ? HOLD : REQ;
            default: state_nxt = IDLE;
        endcase
        // a grant for an already-squashed request must not advance the PC past the redirect target
        pcf_nxt = redir ? {PCBranchD[31:2], 2'b00}
                : (state == REQ && imem.gnt && !drop) ? PCF + 32'd4 : PCF;
        deliver_mem  = state == WAIT && imem.rvalid && !drop && !StallF && !redir;
        deliver_skid = state == HOLD && !StallF && !redir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            PCF        <= RESET_PC;
            req_addr   <= '0;
            resp_pc    <= '0;
            drop       <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            InstrD     <= NOP_INSTR;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
        end else begin
            state <= state_nxt;
            PCF   <= pcf_nxt;
            if (state_nxt == REQ && state != REQ)
                req_addr <= pcf_nxt;
            if (state == REQ && imem.gnt)
                resp_pc <= req_addr;
            if (state == WAIT && imem.rvalid)
                drop <= 1'b0;
            else if (redir && (state == REQ || state == WAIT))
                drop <= 1'b1;
            if (state == WAIT && imem.rvalid && !drop && StallF) begin
                skid_instr <= imem.rdata;
                skid_pc4   <= resp_pc + 32'd4;
            end
            if (!StallF) begin
                ValidD <= deliver_mem || deliver_skid;
                InstrD <= deliver_mem ? imem.rdata : deliver_skid ? skid_instr : NOP_INSTR;
                if (deliver_mem)
                    PCPlus4D <= resp_pc + 32'd4;
                else if (deliver_skid)
                    PCPlus4D <= skid_pc4;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: per-cycle directed vectors for the fetch stage plus reset corner sequences.
module tb_instruction_fetch;
    localparam logic F = 1'b0;
    localparam logic T = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n, StallF, PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] PCF, InstrD, PCPlus4D, PCF1, InstrD1, PCPlus4D1;
    logic        ValidD, ValidD1;

    imem_if m0();
    imem_if m1();

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .imem(m0), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst1_n), .StallF(1'b0), .PCSrcD(1'b0), .PCBranchD(32'h0),
        .imem(m1), .PCF(PCF1), .InstrD(InstrD1), .PCPlus4D(PCPlus4D1), .ValidD(ValidD1)
    );

    typedef struct {
        logic        stall, src;
        logic [31:0] br;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr, pcf, instr, pc4;
        logic        valid;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    function automatic void add(input logic s, p, input logic [31:0] br, input logic g, r,
                                input logic [31:0] rd, input logic q, input logic [31:0] a, f, i, p4,
                                input logic v);
        vq.push_back('{s, p, br, g, r, rd, q, a, f, i, p4, v});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit second, input logic q, input logic [31:0] a, f, i, p,
                           input logic v);
        chk({tag, "_req"},   {31'b0, second ? m1.req : m0.req}, {31'b0, q});
        chk({tag, "_addr"},  second ? m1.addr : m0.addr, a);
        chk({tag, "_pcf"},   second ? PCF1 : PCF, f);
        chk({tag, "_instr"}, second ? InstrD1 : InstrD, i);
        chk({tag, "_pc4"},   second ? PCPlus4D1 : PCPlus4D, p);
        chk({tag, "_valid"}, {31'b0, second ? ValidD1 : ValidD}, {31'b0, v});
    endtask

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
        m0.gnt = 1'b0; m0.rvalid = 1'b0; m0.rdata = '0;
        m1.gnt = 1'b0; m1.rvalid = 1'b0; m1.rdata = '0;
        //  stall src br          gnt rv  rdata          | req addr        pcf          instr         pc4          valid
        add(F, F, 32'h0,   F, F, 32'h0,        F, 32'h0,   32'h0,   32'h0,        32'h0,   F);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h0,   32'h0,   32'h0,        32'h0,   F);
        add(F, F, 32'h0,   F, T, 32'h20080005, F, 32'h0,   32'h4,   32'h0,        32'h0,   F);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h4,   32'h4,   32'h20080005, 32'h4,   T);
        add(F, F, 32'h0,   F, T, 32'h20090003, F, 32'h4,   32'h8,   32'h0,        32'h4,   F);
        add(T, F, 32'h0,   T, F, 32'h0,        T, 32'h8,   32'h8,   32'h20090003, 32'h8,   T);
        add(T, F, 32'h0,   F, T, 32'hAAAA0008, F, 32'h8,   32'hC,   32'h20090003, 32'h8,   T);
        add(T, F, 32'h0,   F, F, 32'h0,        F, 32'h8,   32'hC,   32'h20090003, 32'h8,   T);
        add(T, F, 32'h0,   F, F, 32'h0,        F, 32'h8,   32'hC,   32'h20090003, 32'h8,   T);
        add(F, F, 32'h0,   F, F, 32'h0,        F, 32'h8,   32'hC,   32'h20090003, 32'h8,   T);
        add(F, F, 32'h0,   F, F, 32'h0,        T, 32'hC,   32'hC,   32'hAAAA0008, 32'hC,   T);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'hC,   32'hC,   32'h0,        32'hC,   F);
        add(F, F, 32'h0,   F, T, 32'hBBBB000C, F, 32'hC,   32'h10,  32'h0,        32'hC,   F);
        add(T, F, 32'h0,   T, F, 32'h0,        T, 32'h10,  32'h10,  32'hBBBB000C, 32'h10,  T);
        add(F, T, 32'h43,  F, F, 32'h0,        F, 32'h10,  32'h14,  32'hBBBB000C, 32'h10,  T);
        add(F, F, 32'h0,   F, T, 32'hDEAD0010, F, 32'h10,  32'h40,  32'h0,        32'h10,  F);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h40,  32'h40,  32'h0,        32'h10,  F);
        add(F, F, 32'h0,   F, T, 32'hCCCC0040, F, 32'h40,  32'h44,  32'h0,        32'h10,  F);
        add(F, T, 32'h100, F, F, 32'h0,        T, 32'h44,  32'h44,  32'hCCCC0040, 32'h44,  T);
        add(F, T, 32'h100, F, F, 32'h0,        T, 32'h44,  32'h100, 32'h0,        32'h44,  F);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h44,  32'h100, 32'h0,        32'h44,  F);
        add(F, F, 32'h0,   F, T, 32'hDEAD0044, F, 32'h44,  32'h100, 32'h0,        32'h44,  F);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h100, 32'h100, 32'h0,        32'h44,  F);
        add(F, F, 32'h0,   F, T, 32'hEEEE0100, F, 32'h100, 32'h104, 32'h0,        32'h44,  F);
        add(T, T, 32'h200, F, T, 32'hFFFF0000, T, 32'h104, 32'h104, 32'hEEEE0100, 32'h104, T);
        add(T, F, 32'h0,   T, F, 32'h0,        T, 32'h104, 32'h104, 32'hEEEE0100, 32'h104, T);
        add(F, T, 32'h200, F, T, 32'hDEAD0104, F, 32'h104, 32'h108, 32'hEEEE0100, 32'h104, T);
        add(F, F, 32'h0,   T, F, 32'h0,        T, 32'h200, 32'h200, 32'h0,        32'h104, F);
        add(F, F, 32'h0,   F, T, 32'h12340200, F, 32'h200, 32'h204, 32'h0,        32'h104, F);
        add(T, F, 32'h0,   T, F, 32'h0,        T, 32'h204, 32'h204, 32'h12340200, 32'h204, T);
        add(T, F, 32'h0,   F, T, 32'h56780204, F, 32'h204, 32'h208, 32'h12340200, 32'h204, T);
        add(F, T, 32'h300, F, F, 32'h0,        F, 32'h204, 32'h208, 32'h12340200, 32'h204, T);
        add(F, F, 32'h0,   F, F, 32'h0,        T, 32'h300, 32'h300, 32'h0,        32'h204, F);

        repeat (2) @(negedge clk);
        chk_out("reset", 0, F, 32'h0, 32'h0, 32'h0, 32'h0, F);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            StallF = vq[i].stall; PCSrcD = vq[i].src; PCBranchD = vq[i].br;
            m0.gnt = vq[i].gnt; m0.rvalid = vq[i].rv; m0.rdata = vq[i].rd;
            chk_out($sformatf("v%0d", i), 0, vq[i].req, vq[i].addr, vq[i].pcf, vq[i].instr, vq[i].pc4, vq[i].valid);
            @(negedge clk);
        end

        // async reset in the middle of WAIT, with a late rvalid arriving around the release
        StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
        m0.gnt = 1'b1; m0.rvalid = 1'b0; m0.rdata = '0;
        @(negedge clk);
        chk_out("wait_pre_rst", 0, F, 32'h300, 32'h304, 32'h0, 32'h204, F);
        m0.gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, F, 32'h0, 32'h0, 32'h0, 32'h0, F);
        m0.rvalid = 1'b1; m0.rdata = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        chk_out("rst_idle", 0, F, 32'h0, 32'h0, 32'h0, 32'h0, F);
        @(negedge clk);
        chk_out("restart", 0, T, 32'h0, 32'h0, 32'h0, 32'h0, F);
        m0.rvalid = 1'b0; m0.gnt = 1'b1;
        @(negedge clk);
        m0.gnt = 1'b0; m0.rvalid = 1'b1; m0.rdata = 32'h20080005;
        @(negedge clk);
        m0.rvalid = 1'b0;
        chk_out("restart_word", 0, T, 32'h4, 32'h4, 32'h20080005, 32'h4, T);

        // PC wrap-around from a non-zero reset vector
        rst1_n = 1'b1;
        chk_out("wrap_idle", 1, F, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, F);
        @(negedge clk);
        chk_out("wrap_req", 1, T, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, F);
        m1.gnt = 1'b1;
        @(negedge clk);
        m1.gnt = 1'b0;
        chk_out("wrap_wait", 1, F, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, F);
        m1.rvalid = 1'b1; m1.rdata = 32'h11111111;
        @(negedge clk);
        m1.rvalid = 1'b0;
        chk_out("wrap_word", 1, T, 32'h0, 32'h0, 32'h11111111, 32'h0, T);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
